// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//
// Shares one external 8-bit combinational ALU between NUM_REQ requesters.
// A round-robin grant picks one request per IDLE visit. The winner's
// operands and op select are registered onto the ALU inputs. The ALU result
// and flags are captured one cycle later and returned as a tagged response on
// a single valid/ready channel. Sequence: IDLE -> EXEC -> RESP -> IDLE.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b          packed 8-bit operands, requester i at [8i+7:8i]
//   req_sel               packed 3-bit op selects, requester i at [3i+2:3i]
//   alu_a/alu_b/alu_sel   registered drive to the ALU
//   alu_out, alu_flags    ALU result and {P, V, N, Z, C}
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_data/rsp_flags  served requester index, result, flags
//   busy                  high while an operation is in EXEC or RESP
//   op_count              completed responses, wraps to 0
// -----------------------------------------------------------------------------
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_sel,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_sel,
  input  logic [7:0]           alu_out,
  input  logic [4:0]           alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic [4:0]           rsp_flags,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ID_W-1:0]   r_ptr;
  logic [7:0]        r_alu_a;
  logic [7:0]        r_alu_b;
  logic [2:0]        r_alu_sel;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [7:0]        r_rsp_data;
  logic [4:0]        r_rsp_flags;
  logic [CNT_W-1:0]  r_op_count;

  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_gnt_id;
  int                w_idx;
  logic [7:0]        w_gnt_a;
  logic [7:0]        w_gnt_b;
  logic [2:0]        w_gnt_sel;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic              w_take;
  logic              w_capture;
  logic              w_hs;

  // Round-robin search: the first asserted req_valid at or after r_ptr,
  // wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_gnt_vld && req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ID_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_gnt_a   = req_a[8*w_gnt_id +: 8];
    w_gnt_b   = req_b[8*w_gnt_id +: 8];
    w_gnt_sel = req_sel[3*w_gnt_id +: 3];
  end

  // Pointer moves past the requester just served, wrapping explicitly.
  always_comb begin
    if (r_rsp_id == ID_W'(NUM_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_rsp_id + 1'b1;
    end
  end

  // FSM next-state and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_capture   = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_take      = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // req_ready is gated by rst_n so no grant is advertised while reset is held.
  always_comb begin
    req_ready = '0;
    if (w_take && rst_n) begin
      req_ready[w_gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_op_count  <= '0;
    end else begin
      // Grant: operands go straight onto the ALU inputs and hold until the
      // next grant.
      if (w_take) begin
        r_alu_a   <= w_gnt_a;
        r_alu_b   <= w_gnt_b;
        r_alu_sel <= w_gnt_sel;
        r_rsp_id  <= w_gnt_id;
      end
      // End of EXEC: the combinational ALU has had a full cycle to settle.
      if (w_capture) begin
        r_rsp_data  <= alu_out;
        r_rsp_flags <= alu_flags;
        r_rsp_valid <= 1'b1;
      end
      if (w_hs) begin
        r_rsp_valid <= 1'b0;
        r_op_count  <= r_op_count + 1'b1;
        r_ptr       <= w_ptr_nxt;
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_flags = r_rsp_flags;
  assign op_count  = r_op_count;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_arbiter
//
// Drives alu_rr_arbiter with directed and random requests. A simple
// combinational ALU model answers the DUT's ALU port. A transaction-level
// reference model tracks the pending request per requester, the rotating
// priority, the in-flight operation and its age, and the completed count.
// -----------------------------------------------------------------------------
module tb_alu_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [8*N-1:0]   req_a = '0;
  logic [8*N-1:0]   req_b = '0;
  logic [3*N-1:0]   req_sel = '0;
  logic [7:0]       alu_a, alu_b;
  logic [2:0]       alu_sel;
  logic [7:0]       alu_out;
  logic [4:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [IDW-1:0]   rsp_id;
  logic [7:0]       rsp_data;
  logic [4:0]       rsp_flags;
  logic             busy;
  logic [15:0]      op_count;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .busy(busy), .op_count(op_count)
  );

  // Returns {Parity, Overflow, Negative, Zero, Carry, result[7:0]}.
  function automatic logic [12:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] s);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (s)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                  v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = a << 1; c = a[7]; end
      default: begin r = a >> 1; c = a[0]; end
    endcase
    return {^r, v, r[7], (r == 8'd0), c, r};
  endfunction

  assign {alu_flags, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  int tests = 0;
  int fails = 0;

  // reference model state
  logic       want [N];
  logic [7:0] ma [N];
  logic [7:0] mb [N];
  logic [2:0] ms [N];
  int         ptr = 0;
  int         cnt = 0;
  int         age = 0;
  int         cur_id = 0;
  logic       out_q = 1'b0;
  logic [7:0] cur_a, cur_b;
  logic [2:0] cur_s;
  int         cyc = 0;

  // responses observed on the DUT's response channel
  int         done_ids [$];
  logic [7:0] done_data [$];
  logic [4:0] done_flags [$];
  int         done_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = want[i];
      req_a[8*i +: 8]   = ma[i];
      req_b[8*i +: 8]   = mb[i];
      req_sel[3*i +: 3] = ms[i];
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s);
    want[i] = 1'b1; ma[i] = a; mb[i] = b; ms[i] = s;
  endtask

  // One clock: drive, check against the model, advance the model, then wait
  // for the next falling edge.
  task automatic step();
    int           g;
    logic [12:0]  r;
    logic [N-1:0] er;
    drive();
    #1;
    g = -1;
    if (!out_q) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && want[(ptr + k) % N]) g = (ptr + k) % N;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(out_q));
    chk("rsp_valid", 32'(rsp_valid), 32'(out_q && age >= 1));
    chk("op_count", 32'(op_count), cnt & 32'hFFFF);
    if (out_q) begin
      chk("alu_a", 32'(alu_a), 32'(cur_a));
      chk("alu_b", 32'(alu_b), 32'(cur_b));
      chk("alu_sel", 32'(alu_sel), 32'(cur_s));
    end
    if (out_q && age >= 1) begin
      r = alu_fn(cur_a, cur_b, cur_s);
      chk("rsp_id", 32'(rsp_id), cur_id);
      chk("rsp_data", 32'(rsp_data), 32'(r[7:0]));
      chk("rsp_flags", 32'(rsp_flags), 32'(r[12:8]));
    end
    if (rsp_valid && rsp_ready) begin
      done_ids.push_back(int'(rsp_id));
      done_data.push_back(rsp_data);
      done_flags.push_back(rsp_flags);
      done_cyc.push_back(cyc);
    end
    if (out_q && age >= 1 && rsp_ready) begin
      out_q = 1'b0;
      ptr   = (cur_id + 1) % N;
      cnt++;
    end else if (out_q) begin
      age++;
    end
    if (g >= 0) begin
      out_q  = 1'b1;
      age    = 0;
      cur_id = g;
      cur_a  = ma[g];
      cur_b  = mb[g];
      cur_s  = ms[g];
      want[g] = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  // Called at a falling edge: holds reset for two clocks and checks the
  // reset values while it is asserted.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_flags", 32'(rsp_flags), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_sel", 32'(alu_sel), 0);
    out_q = 1'b0; ptr = 0; cnt = 0; age = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc += 2;
  endtask

  task automatic run_until(input int target, input int limit);
    int n;
    n = 0;
    while (done_ids.size() < target && n < limit) begin
      step();
      n++;
    end
    chk("txn_timeout", done_ids.size(), target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < N; i++) begin
      want[i] = 1'b0; ma[i] = '0; mb[i] = '0; ms[i] = '0;
    end
    @(negedge clk);
    do_reset();

    // single request from requester 2: 100 + 50
    rsp_ready = 1'b1;
    set_req(2, 8'd100, 8'd50, 3'd0);
    drive();
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'h4);
    step();
    chk("t1_exec_valid", 32'(rsp_valid), 0);
    chk("t1_exec_ready", 32'(req_ready), 0);
    step();
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 2);
    chk("t1_rsp_data", 32'(rsp_data), 32'h96);
    chk("t1_rsp_flags", 32'(rsp_flags), 32'b01100);
    step();
    chk("t1_op_count", 32'(op_count), 1);
    chk("t1_valid_clr", 32'(rsp_valid), 0);

    // all four continuously valid: order 0,1,2,3,0 every 3 cycles
    do_reset();
    base = done_ids.size();
    for (int n = 0; n < 40 && done_ids.size() < base + 5; n++) begin
      for (int i = 0; i < N; i++) set_req(i, 8'(i), 8'd1, 3'd0);
      step();
    end
    chk("t2_count", done_ids.size(), base + 5);
    for (int k = 0; k < 5; k++) begin
      if (done_ids.size() > base + k) begin
        chk("t2_id", done_ids[base + k], k % 4);
        chk("t2_data", 32'(done_data[base + k]), (k % 4) + 1);
        if (k > 0) chk("t2_spacing", done_cyc[base + k] - done_cyc[base + k - 1], 3);
      end
    end
    for (int i = 0; i < N; i++) want[i] = 1'b0;

    // backpressure: 5 stalled cycles in RESP
    do_reset();
    rsp_ready = 1'b0;
    set_req(1, 8'd5, 8'd6, 3'd2);
    set_req(3, 8'd9, 8'd3, 3'd1);
    for (int n = 0; n < 5 && !rsp_valid; n++) step();
    chk("t3_reach_resp", 32'(rsp_valid), 1);
    base = done_ids.size();
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t3_stall_valid", 32'(rsp_valid), 1);
      chk("t3_stall_id", 32'(rsp_id), 1);
      chk("t3_stall_data", 32'(rsp_data), 4);
      chk("t3_stall_ready", 32'(req_ready), 0);
    end
    chk("t3_no_hs", done_ids.size(), base);
    rsp_ready = 1'b1;
    step();
    chk("t3_hs", done_ids.size(), base + 1);
    chk("t3_valid_clr", 32'(rsp_valid), 0);
    run_until(base + 2, 10);
    if (done_ids.size() >= base + 2) chk("t3_next_id", done_ids[base + 1], 3);

    // fairness: 1 served, then 0 and 1 both valid -> 0 then 1
    do_reset();
    base = done_ids.size();
    set_req(1, 8'd1, 8'd1, 3'd0);
    run_until(base + 1, 10);
    set_req(0, 8'd2, 8'd2, 3'd0);
    set_req(1, 8'd3, 8'd3, 3'd0);
    run_until(base + 3, 20);
    if (done_ids.size() >= base + 3) begin
      chk("t4_first", done_ids[base], 1);
      chk("t4_second", done_ids[base + 1], 0);
      chk("t4_third", done_ids[base + 2], 1);
    end

    // overflow pass-through: 127 + 1
    base = done_ids.size();
    set_req(2, 8'd127, 8'd1, 3'd0);
    run_until(base + 1, 10);
    if (done_ids.size() >= base + 1) begin
      chk("t5_data", 32'(done_data[base]), 32'h80);
      chk("t5_ovf", 32'(done_flags[base][3]), 1);
      chk("t5_neg", 32'(done_flags[base][2]), 1);
      chk("t5_flags", 32'(done_flags[base]), 32'b11100);
    end

    // reset while in EXEC aborts the operation
    set_req(3, 8'd10, 8'd20, 3'd3);
    step();
    chk("t6_exec_busy", 32'(busy), 1);
    base = done_ids.size();
    set_req(0, 8'd7, 8'd8, 3'd4);
    drive();
    do_reset();
    step();
    chk("t6_no_rsp", 32'(rsp_valid), 0);
    set_req(3, 8'd11, 8'd12, 3'd1);
    run_until(base + 2, 20);
    if (done_ids.size() >= base + 2) begin
      chk("t6_first", done_ids[base], 0);
      chk("t6_second", done_ids[base + 1], 3);
    end

    // random traffic with random backpressure and all op selects
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!want[i] && $urandom_range(0, 2) == 0)
          set_req(i, 8'($urandom), 8'($urandom), 3'($urandom));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) want[i] = 1'b0;
    for (int n = 0; n < 6; n++) step();
    chk("final_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one 8-bit ALU datapath (3-bit op select; Carry, Zero, Negative, Overflow and Parity flags) between NUM_REQ independent requesters.
- Round-robin arbitration; valid/ready handshake per requester.
- Drives the ALU operand/select inputs from registered operands and captures result plus flags.
- Returns one tagged response per accepted request on a single valid/ready response channel.
- Sits between client blocks (sequencers, test drivers) and the single ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of requester ID.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  in  8*NUM_REQ  operand B, same packing.
- req_sel  in  3*NUM_REQ  op select; requester i uses [3i+2:3i].
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_sel  out  3  to ALU ALU_Sel.
- alu_out  in  8  ALU result.
- alu_flags  in  5  {Parity, Overflow, Negative, Zero, Carry} from ALU.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester served.
- rsp_data  out  8  captured ALU result.
- rsp_flags  out  5  captured flags, same packing as alu_flags.
- busy  out  1  high in EXEC or RESP.
- op_count  out  CNT_W  completed responses, wraps to 0.

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, alu_a/alu_b/alu_sel 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_flags 0, op_count 0, busy 0, req_ready 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is the first asserted req_valid searching from the rr pointer upward, modulo NUM_REQ.
  - req_ready[grant] asserts combinationally in the same cycle.
  - On that edge, operands and select latch into alu_a/alu_b/alu_sel and grant latches into rsp_id; next state EXEC.
  - If no req_valid is asserted: stay in IDLE, req_ready = 0.
- EXEC:
  - ALU is combinational; alu_out and alu_flags are sampled at end of EXEC into rsp_data and rsp_flags.
  - rsp_valid is set; next state RESP.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_data and rsp_flags stay stable until handshake.
  - On rsp_valid && rsp_ready: rsp_valid clears, op_count increments, rr pointer = rsp_id+1 mod NUM_REQ, next state IDLE.
  - rsp_ready low stalls indefinitely; no new grants while stalled.
- alu_a/alu_b/alu_sel hold their values in EXEC, RESP and IDLE until the next grant.
- req_ready is never asserted outside IDLE.
- Latency: request accepted at edge T, rsp_valid high from T+2. Peak throughput is one op per 3 cycles.
- Requester rules: a requester keeps req_valid and its fields stable until its req_ready. The block does not check this.
- All 8 select codes are forwarded unmodified, including 3'b100; the block does not interpret ops.
- Simultaneous requests: exactly one grant per IDLE cycle. With all requesters continuously valid, service order is 0,1,2,3,0,...
- A sole continuously-valid requester is granted on every IDLE visit.
- op_count wraps from 2^CNT_W-1 to 0.
- Reset mid-operation aborts the operation. No response is emitted and the rr pointer returns to 0.

Test Plan:
- Single request: req 2 valid with A=100, B=50, sel=000 at edge T -> req_ready[2] high for 1 cycle; rsp_valid high from T+2 with rsp_id=2, rsp_data=0x96, rsp_flags equal to alu_flags sampled in EXEC; op_count=1 after handshake.
- All four requesters valid continuously, rsp_ready tied high: requester i supplies A=i, B=1, sel=000 -> responses in order ids 0,1,2,3,0 with data 1,2,3,4,1, spaced 3 cycles apart.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable; req_ready stays 0 despite pending requests. The response completes on the first cycle rsp_ready is high.
- Fairness after stall: req 1 served, then req 1 and req 0 both valid -> req 0 granted next (pointer at 2 wraps to 0), req 1 after it.
- Overflow pass-through: A=127, B=1, sel=000 -> rsp_data=0x80; rsp_flags[3] (Overflow) and rsp_flags[2] (Negative) match ALU outputs of 1.
- Reset in EXEC: drop rst_n for 1 cycle -> no rsp_valid; all outputs 0; next request from requester 3 with requester 0 also valid -> requester 0 granted first.
